// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-port memory between instruction fetch (IF) and data
// access (MEM). Only one transaction is in flight at a time. Data access wins
// ties, but a streak counter makes sure a waiting fetch gets in after at most
// MEM_STREAK consecutive data grants.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req_i/if_addr_i       fetch request (held until if_done_o) and address
//   if_flush_i               drop the outstanding fetch (redirect)
//   if_rdata_o/if_done_o     fetched word and its one-cycle completion pulse
//   if_stall_o               fetch stall request (combinational)
//   mem_req_i/mem_we_i       data request (held until mem_done_o), store flag
//   mem_addr_i/mem_wdata_i   data address, store data
//   mem_be_i                 store byte enables
//   mem_rdata_o/mem_done_o   load data and its one-cycle completion pulse
//   mem_stall_o              data stall request (combinational)
//   ram_req_o..ram_be_o      registered memory command
//   ram_gnt_i                memory accepts the command this cycle
//   ram_rvalid_i/ram_rdata_i memory response (reads and writes)
//   dbg_state                current FSM state (0 IDLE, 1 REQ, 2 WAIT)
//
// Memory handshake: ram_req_o is the command valid and ram_gnt_i its ready.
// The command is transferred in the cycle both are high; until then every
// ram_* field is held stable, and a command is never withdrawn once raised.
// Exactly one ram_rvalid_i per transferred command closes the transaction;
// rvalid is ignored outside the WAIT state.

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_done_o,
    output logic                if_stall_o,

    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_be_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_done_o,
    output logic                mem_stall_o,

    output logic                ram_req_o,
    output logic                ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    output logic [DATA_W/8-1:0] ram_be_o,
    input  logic                ram_gnt_i,
    input  logic                ram_rvalid_i,
    input  logic [DATA_W-1:0]   ram_rdata_i,

    output logic [1:0]          dbg_state
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(MEM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MEM_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    state_t              state;
    owner_t              owner;
    logic                discard;
    logic [STREAK_W-1:0] streak;

    logic if_elig;
    logic mem_elig;
    logic pick_mem;
    logic if_flush_owned;

    // A port whose done pulse is showing this cycle is still presenting the
    // request it just completed, so it must not be granted again.
    always_comb begin
        if_elig        = if_req_i & ~if_done_o & ~if_flush_i;
        mem_elig       = mem_req_i & ~mem_done_o;
        pick_mem       = mem_elig & (~if_elig | (streak < STREAK_MAX));
        if_flush_owned = (owner == OWN_IF) & if_flush_i;
    end

    assign if_stall_o  = if_req_i & ~if_done_o & ~if_flush_i;
    assign mem_stall_o = mem_req_i & ~mem_done_o;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            discard     <= 1'b0;
            streak      <= '0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            ram_be_o    <= '0;
            if_rdata_o  <= '0;
            if_done_o   <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pick_mem) begin
                        owner       <= OWN_MEM;
                        ram_req_o   <= 1'b1;
                        ram_we_o    <= mem_we_i;
                        ram_addr_o  <= mem_addr_i;
                        ram_wdata_o <= mem_wdata_i;
                        ram_be_o    <= mem_be_i;
                        // Only grants taken while a fetch is waiting count
                        // towards the streak.
                        streak      <= if_elig ? streak + 1'b1 : '0;
                        state       <= ST_REQ;
                    end else if (if_elig) begin
                        owner       <= OWN_IF;
                        ram_req_o   <= 1'b1;
                        ram_we_o    <= 1'b0;
                        ram_addr_o  <= if_addr_i;
                        ram_wdata_o <= '0;
                        ram_be_o    <= {BE_W{1'b1}};
                        streak      <= '0;
                        state       <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (if_flush_owned) begin
                        discard <= 1'b1;
                    end
                    if (ram_gnt_i) begin
                        ram_req_o <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (if_flush_owned) begin
                        discard <= 1'b1;
                    end
                    if (ram_rvalid_i) begin
                        state <= ST_IDLE;
                        if (owner == OWN_MEM) begin
                            mem_done_o <= 1'b1;
                            if (!ram_we_o) begin
                                mem_rdata_o <= ram_rdata_i;
                            end
                        end else begin
                            // A flush seen at any point of the fetch, including
                            // this very cycle, turns the response into a no-op.
                            discard <= 1'b0;
                            if (!(discard | if_flush_i)) begin
                                if_done_o  <= 1'b1;
                                if_rdata_o <= ram_rdata_i;
                            end
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int STREAK = 4;

  // clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          if_req_i, if_flush_i, if_done_o, if_stall_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          mem_req_i, mem_we_i, mem_done_o, mem_stall_o;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i, mem_rdata_o;
  logic [BW-1:0] mem_be_i;
  logic          ram_req_o, ram_we_o, ram_gnt_i, ram_rvalid_i;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;
  logic [BW-1:0] ram_be_o;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_STREAK(STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .mem_stall_o(mem_stall_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_gnt_i(ram_gnt_i),
    .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .dbg_state(dbg_state)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Memory responder: 0 = driven by the scenario, 1 = fixed delays, 2 = random.
  int resp_mode = 0;
  int gnt_delay = 0, rv_delay = 0, gnt_wait = 0, rv_wait = 0;
  bit rv_pending = 0;

  // Reference model: one transaction record plus the visible port results.
  bit            tx_busy, tx_accepted, tx_mem, tx_discard;
  bit            tx_we;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_wdata;
  logic [BW-1:0] tx_be;
  int            m_streak;
  bit            m_if_done, m_mem_done;
  logic [DW-1:0] m_if_rdata, m_mem_rdata;

  task automatic model_step();
    bit if_el, mem_el, nd_if, nd_mem;
    if (rst) begin
      tx_busy = 0; tx_accepted = 0; tx_discard = 0; m_streak = 0;
      m_if_done = 0; m_mem_done = 0; m_if_rdata = '0; m_mem_rdata = '0;
      return;
    end
    nd_if = 0; nd_mem = 0;
    if (!tx_busy) begin
      if_el  = if_req_i && !m_if_done && !if_flush_i;
      mem_el = mem_req_i && !m_mem_done;
      if (mem_el && (!if_el || m_streak < STREAK)) begin
        tx_busy = 1; tx_accepted = 0; tx_mem = 1;
        tx_we = mem_we_i; tx_addr = mem_addr_i; tx_wdata = mem_wdata_i; tx_be = mem_be_i;
        m_streak = if_el ? m_streak + 1 : 0;
      end else if (if_el) begin
        tx_busy = 1; tx_accepted = 0; tx_mem = 0;
        tx_we = 0; tx_addr = if_addr_i; tx_wdata = '0; tx_be = '1;
        m_streak = 0;
      end
    end else begin
      if (!tx_mem && if_flush_i) tx_discard = 1;
      if (!tx_accepted) begin
        if (ram_gnt_i) tx_accepted = 1;
      end else if (ram_rvalid_i) begin
        tx_busy = 0;
        if (tx_mem) begin
          nd_mem = 1;
          if (!tx_we) m_mem_rdata = ram_rdata_i;
        end else begin
          if (!tx_discard) begin nd_if = 1; m_if_rdata = ram_rdata_i; end
          tx_discard = 0;
        end
      end
    end
    m_if_done = nd_if; m_mem_done = nd_mem;
  endtask

  // driver tasks
  task automatic set_resp(input int mode, input int gd, input int rd);
    resp_mode = mode; gnt_delay = gd; rv_delay = rd;
    gnt_wait = 0; rv_wait = 0; rv_pending = 0;
    ram_gnt_i = 0; ram_rvalid_i = 0;
  endtask

  // One clock: responder decides this cycle's ram inputs, edge, model update.
  task automatic cycle();
    bit take;
    if (resp_mode != 0) begin
      ram_gnt_i = 0; ram_rvalid_i = 0; ram_rdata_i = $urandom;
      if (ram_req_o) begin
        take = (resp_mode == 1) ? (gnt_wait >= gnt_delay) : ($urandom_range(0, 2) == 0);
        if (take) begin
          ram_gnt_i = 1; gnt_wait = 0; rv_pending = 1; rv_wait = 0;
        end else begin
          gnt_wait++;
          if (resp_mode == 2 && $urandom_range(0, 7) == 0) ram_rvalid_i = 1;
        end
      end else if (rv_pending) begin
        take = (resp_mode == 1) ? (rv_wait >= rv_delay) : ($urandom_range(0, 1) == 0);
        if (take) begin ram_rvalid_i = 1; rv_pending = 0; end
        else rv_wait++;
      end
    end
    @(posedge clk);
    model_step();
    if (rst) begin rv_pending = 0; gnt_wait = 0; rv_wait = 0; end
    @(negedge clk);
  endtask

  task automatic start_test();
    if_req_i = 0; if_flush_i = 0; if_addr_i = '0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0;
    set_resp(0, 0, 0); ram_rdata_i = '0;
    rst = 1; cycle(); rst = 0;
  endtask

  task automatic test_reset();
    if_req_i = 0; if_flush_i = 0; if_addr_i = '0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0;
    set_resp(0, 0, 0); ram_rdata_i = '0;
    rst = 1; cycle(); cycle(); rst = 0;
    n_run++; if (ram_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_ram_req: got %0b want 0", ram_req_o); end
    n_run++; if ({ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o} !== '0) begin n_fail++; $display("FAIL reset_ram_cmd: got %0b %h %h %h want all 0", ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o); end
    n_run++; if ({if_done_o, mem_done_o} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", {if_done_o, mem_done_o}); end
    n_run++; if ({if_rdata_o, mem_rdata_o} !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata_o, mem_rdata_o); end
    n_run++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  // Fetch with immediate grant and response: done exactly at N+3.
  task automatic test_if_read();
    start_test();
    if_addr_i = 32'h100; if_req_i = 1;
    #1;
    n_run++; if (if_stall_o !== 1'b1) begin n_fail++; $display("FAIL if_read_stall_n: got %0b want 1", if_stall_o); end
    cycle();
    n_run++; if ({ram_req_o, ram_we_o, ram_be_o} !== {1'b1, 1'b0, 4'hf}) begin n_fail++; $display("FAIL if_read_cmd: got req=%0b we=%0b be=%h want 1 0 f", ram_req_o, ram_we_o, ram_be_o); end
    n_run++; if (ram_addr_o !== 32'h100) begin n_fail++; $display("FAIL if_read_addr: got %h want 00000100", ram_addr_o); end
    n_run++; if (if_stall_o !== 1'b1) begin n_fail++; $display("FAIL if_read_stall_n1: got %0b want 1", if_stall_o); end
    ram_gnt_i = 1; cycle(); ram_gnt_i = 0;
    n_run++; if ({ram_req_o, if_done_o, if_stall_o} !== 3'b001) begin n_fail++; $display("FAIL if_read_wait: got req,done,stall=%b want 001", {ram_req_o, if_done_o, if_stall_o}); end
    ram_rvalid_i = 1; ram_rdata_i = 32'h00500093; cycle(); ram_rvalid_i = 0; ram_rdata_i = 32'hFFFF_FFFF;
    n_run++; if (if_done_o !== 1'b1) begin n_fail++; $display("FAIL if_read_done: got %0b want 1", if_done_o); end
    n_run++; if (if_rdata_o !== 32'h00500093) begin n_fail++; $display("FAIL if_read_rdata: got %h want 00500093", if_rdata_o); end
    n_run++; if (if_stall_o !== 1'b0) begin n_fail++; $display("FAIL if_read_stall_done: got %0b want 0", if_stall_o); end
    if_req_i = 0; cycle();
    n_run++; if ({if_done_o, ram_req_o} !== 2'b00) begin n_fail++; $display("FAIL if_read_pulse: got done,req=%b want 00", {if_done_o, ram_req_o}); end
    n_run++; if (if_rdata_o !== 32'h00500093) begin n_fail++; $display("FAIL if_read_hold: got %h want 00500093", if_rdata_o); end
  endtask

  // Both requests together: MEM first, then IF, never overlapping dones.
  task automatic test_simultaneous();
    logic [AW-1:0] addrs[$];
    logic [DW-1:0] rv_data;
    bit prev = 0, mem_first = 0;
    int mem_seen = 0, if_seen = 0, both = 0;
    start_test(); set_resp(1, 0, 0);
    if_req_i = 1; if_addr_i = 32'h104;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h2000; mem_be_i = 4'hf;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (ram_rvalid_i) rv_data = ram_rdata_i;
      if (ram_req_o && !prev) addrs.push_back(ram_addr_o);
      prev = ram_req_o;
      if (if_done_o && mem_done_o) both++;
      if (mem_done_o) begin
        mem_seen++; if (if_seen == 0) mem_first = 1; mem_req_i = 0;
        n_run++; if (mem_rdata_o !== rv_data) begin n_fail++; $display("FAIL simul_mem_rdata: got %h want %h", mem_rdata_o, rv_data); end
      end
      if (if_done_o) begin
        if_seen++; if_req_i = 0;
        n_run++; if (if_rdata_o !== rv_data) begin n_fail++; $display("FAIL simul_if_rdata: got %h want %h", if_rdata_o, rv_data); end
      end
    end
    n_run++; if (addrs.size() != 2) begin n_fail++; $display("FAIL simul_cmd_count: got %0d want 2", addrs.size()); end
    else begin
      n_run++; if (addrs[0] !== 32'h2000 || addrs[1] !== 32'h104) begin n_fail++; $display("FAIL simul_order: got %h,%h want 00002000,00000104", addrs[0], addrs[1]); end
    end
    n_run++; if (mem_seen != 1 || if_seen != 1 || !mem_first) begin n_fail++; $display("FAIL simul_dones: got mem=%0d if=%0d mem_first=%0b want 1 1 1", mem_seen, if_seen, mem_first); end
    n_run++; if (both != 0) begin n_fail++; $display("FAIL simul_overlap: got %0d want 0", both); end
  endtask

  // Store with a 3-cycle grant delay; a concurrent fetch flush must not matter.
  task automatic test_store();
    logic [DW-1:0] old;
    int req_cycles = 0, dones = 0, bad_cmd = 0;
    start_test(); set_resp(1, 3, 0);
    old = mem_rdata_o;
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h2004; mem_wdata_i = 32'hDEADBEEF; mem_be_i = 4'h3;
    if_flush_i = 1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (ram_req_o) begin
        req_cycles++;
        if ({ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o} !== {1'b1, 32'h2004, 32'hDEADBEEF, 4'h3}) bad_cmd++;
      end
      if (mem_done_o) begin
        dones++; mem_req_i = 0;
        n_run++; if (ram_rvalid_i !== 1'b1) begin n_fail++; $display("FAIL store_done_timing: rvalid last cycle=%0b want 1", ram_rvalid_i); end
      end
    end
    if_flush_i = 0;
    n_run++; if (req_cycles != 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d want 4", req_cycles); end
    n_run++; if (bad_cmd != 0) begin n_fail++; $display("FAIL store_cmd_stable: got %0d bad cycles want 0", bad_cmd); end
    n_run++; if (dones != 1) begin n_fail++; $display("FAIL store_done_count: got %0d want 1", dones); end
    n_run++; if (mem_rdata_o !== old) begin n_fail++; $display("FAIL store_rdata_kept: got %h want %h", mem_rdata_o, old); end
  endtask

  // Fetch flushed in WAIT, refetch of the new target, then flush with rvalid.
  task automatic test_flush();
    logic [DW-1:0] old;
    start_test();
    old = if_rdata_o;
    if_req_i = 1; if_addr_i = 32'h200; cycle();
    n_run++; if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h200) begin n_fail++; $display("FAIL flush_first_cmd: got req=%0b addr=%h want 1 00000200", ram_req_o, ram_addr_o); end
    ram_gnt_i = 1; cycle(); ram_gnt_i = 0;
    if_flush_i = 1; if_addr_i = 32'h300; cycle(); if_flush_i = 0;
    ram_rvalid_i = 1; ram_rdata_i = 32'hBADC0DE0; cycle(); ram_rvalid_i = 0;
    n_run++; if (if_done_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %0b want 0", if_done_o); end
    n_run++; if (if_rdata_o !== old) begin n_fail++; $display("FAIL flush_rdata_kept: got %h want %h", if_rdata_o, old); end
    cycle();
    n_run++; if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h300) begin n_fail++; $display("FAIL flush_refetch_cmd: got req=%0b addr=%h want 1 00000300", ram_req_o, ram_addr_o); end
    ram_gnt_i = 1; cycle(); ram_gnt_i = 0;
    ram_rvalid_i = 1; ram_rdata_i = 32'h13000093; cycle(); ram_rvalid_i = 0;
    n_run++; if (if_done_o !== 1'b1 || if_rdata_o !== 32'h13000093) begin n_fail++; $display("FAIL flush_refetch_done: got done=%0b data=%h want 1 13000093", if_done_o, if_rdata_o); end
    if_addr_i = 32'h310; cycle();
    cycle();
    n_run++; if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h310) begin n_fail++; $display("FAIL flush_third_cmd: got req=%0b addr=%h want 1 00000310", ram_req_o, ram_addr_o); end
    ram_gnt_i = 1; cycle(); ram_gnt_i = 0;
    ram_rvalid_i = 1; if_flush_i = 1; ram_rdata_i = 32'h0000_7777; cycle(); ram_rvalid_i = 0; if_flush_i = 0;
    n_run++; if (if_done_o !== 1'b0 || if_rdata_o !== 32'h13000093) begin n_fail++; $display("FAIL flush_same_cycle: got done=%0b data=%h want 0 13000093", if_done_o, if_rdata_o); end
    if_req_i = 0; cycle();
  endtask

  // MEM back to back while a fetch waits; the fetch is kept out of each MEM
  // completion cycle by a flush so the streak can build up.
  task automatic test_starvation();
    logic [5:0] exp_order;
    bit prev = 0, got;
    int ngr = 0;
    exp_order = 6'b101111;
    start_test(); set_resp(1, 0, 0);
    if_req_i = 1; if_addr_i = 32'h400;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h3000; mem_be_i = 4'hf;
    for (int c = 0; c < 70; c++) begin
      cycle();
      if (ram_req_o && !prev) begin
        if (ngr < 6) begin
          got = (ram_addr_o !== 32'h400);
          n_run++; if (got !== exp_order[ngr]) begin n_fail++; $display("FAIL starve_grant%0d: got mem=%0b want mem=%0b", ngr, got, exp_order[ngr]); end
        end
        ngr++;
      end
      prev = ram_req_o;
      if (if_done_o) if_req_i = 0;
      if (mem_done_o) begin
        if (ngr >= 6) mem_req_i = 0;
        else mem_addr_i = mem_addr_i + 32'd4;
        if_flush_i = if_req_i;
      end else begin
        if_flush_i = 0;
      end
    end
    n_run++; if (ngr != 6) begin n_fail++; $display("FAIL starve_grant_count: got %0d want 6", ngr); end
  endtask

  // Reset while waiting for a response; the late response must be ignored.
  task automatic test_reset_mid_wait();
    int dones = 0;
    logic [DW-1:0] rv_data;
    start_test();
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h5000; mem_be_i = 4'hf; cycle();
    ram_gnt_i = 1; cycle(); ram_gnt_i = 0;
    rst = 1; mem_req_i = 0; cycle(); rst = 0;
    n_run++; if (ram_req_o !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_wait_idle: got req=%0b state=%0d want 0 0", ram_req_o, dbg_state); end
    ram_rvalid_i = 1; ram_rdata_i = 32'hCAFE0001; cycle(); ram_rvalid_i = 0;
    for (int c = 0; c < 3; c++) begin
      if (mem_done_o || if_done_o) dones++;
      cycle();
    end
    n_run++; if (dones != 0 || mem_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_stale_rvalid: got dones=%0d rdata=%h want 0 00000000", dones, mem_rdata_o); end
    n_run++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_stale_state: got %0d want 0", dbg_state); end
    set_resp(1, 1, 1);
    mem_req_i = 1; mem_addr_i = 32'h5004;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (ram_rvalid_i) rv_data = ram_rdata_i;
      if (mem_done_o) begin
        dones++; mem_req_i = 0;
        n_run++; if (mem_rdata_o !== rv_data) begin n_fail++; $display("FAIL rst_next_rdata: got %h want %h", mem_rdata_o, rv_data); end
      end
    end
    n_run++; if (dones != 1) begin n_fail++; $display("FAIL rst_next_done: got %0d want 1", dones); end
  endtask

  // Random requesters and memory timing, checked every cycle against the model.
  task automatic test_random();
    bit exp_req;
    start_test(); set_resp(2, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      exp_req = tx_busy && !tx_accepted;
      n_run++; if (ram_req_o !== exp_req) begin n_fail++; $display("FAIL rand_ram_req @%0d: got %0b want %0b", c, ram_req_o, exp_req); end
      if (exp_req) begin
        n_run++; if ({ram_we_o, ram_addr_o, ram_be_o} !== {tx_we, tx_addr, tx_be}) begin n_fail++; $display("FAIL rand_cmd @%0d: got %0b %h %h want %0b %h %h", c, ram_we_o, ram_addr_o, ram_be_o, tx_we, tx_addr, tx_be); end
        if (tx_mem) begin
          n_run++; if (ram_wdata_o !== tx_wdata) begin n_fail++; $display("FAIL rand_wdata @%0d: got %h want %h", c, ram_wdata_o, tx_wdata); end
        end
      end
      n_run++; if ({if_done_o, mem_done_o} !== {m_if_done, m_mem_done}) begin n_fail++; $display("FAIL rand_done @%0d: got if,mem=%b want %b", c, {if_done_o, mem_done_o}, {m_if_done, m_mem_done}); end
      n_run++; if (if_rdata_o !== m_if_rdata) begin n_fail++; $display("FAIL rand_if_rdata @%0d: got %h want %h", c, if_rdata_o, m_if_rdata); end
      n_run++; if (mem_rdata_o !== m_mem_rdata) begin n_fail++; $display("FAIL rand_mem_rdata @%0d: got %h want %h", c, mem_rdata_o, m_mem_rdata); end
      n_run++; if (if_stall_o !== (if_req_i & ~m_if_done & ~if_flush_i)) begin n_fail++; $display("FAIL rand_if_stall @%0d: got %0b", c, if_stall_o); end
      n_run++; if (mem_stall_o !== (mem_req_i & ~m_mem_done)) begin n_fail++; $display("FAIL rand_mem_stall @%0d: got %0b", c, mem_stall_o); end

      if (if_req_i && if_done_o) if_req_i = 0;
      if_flush_i = ($urandom_range(0, 9) == 0);
      if (if_flush_i) begin
        if_req_i = $urandom_range(0, 1); if_addr_i = $urandom & 32'h0000_FFFC;
      end else if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom & 32'h0000_FFFC;
      end
      if (mem_req_i && mem_done_o) mem_req_i = 0;
      if (!mem_req_i && $urandom_range(0, 2) == 0) begin
        mem_req_i = 1; mem_we_i = $urandom_range(0, 1);
        mem_addr_i = $urandom & 32'h0001_FFFC; mem_wdata_i = $urandom; mem_be_i = BW'($urandom_range(1, 15));
      end
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_if_read();
    test_simultaneous();
    test_store();
    test_flush();
    test_starvation();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
